// File: rtl/spi_prog_pkg.sv
// Shared constants, address helpers and frame-phase type
// for the SPI configuration register-file programmer.
package spi_prog_pkg;

    // Key written to the apply address to commit shadow to live.
    localparam logic [7:0] APPLY_MAGIC = 8'hA5;

    typedef enum logic [1:0] {
        PH_CMD,
        PH_DATA,
        PH_DONE
    } phase_e;

    // RW flag position inside the command word (its MSB).
    function automatic int rw_bit(input int addr_w);
        return addr_w;
    endfunction

    function automatic int apply_addr(input int addr_w);
        return (1 << addr_w) - 1;
    endfunction

    function automatic int status_addr(input int addr_w);
        return (1 << addr_w) - 2;
    endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: bit counter, SDI shifter,
// frame-phase tracking, truncated-frame detection.
module spi_frame_rx
    import spi_prog_pkg::*;
#(
    parameter int CMD_W  = 8,
    parameter int DATA_W = 8
) (
    input  logic                      SCLK,
    input  logic                      reset,
    input  logic                      CS,
    input  logic                      SDI,
    output phase_e                    phase,
    output logic                      cmd_valid,
    output logic                      done,
    output logic                      abort,
    output logic [CMD_W+DATA_W-1:0]   frame
);

    localparam int FRAME_LEN = CMD_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    localparam logic [CNT_W-1:0] CNT_CMD_LAST = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] CNT_CMD      = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_LEN);

    logic [CNT_W-1:0]     cnt;
    logic [FRAME_LEN-1:0] sreg;
    logic                 active;
    logic                 first_bit;
    logic                 in_frame;

    // A bit is captured on this posedge only while selected and not saturated.
    assign active    = !CS && (cnt != CNT_FULL);
    assign first_bit = active && (cnt == '0);
    assign cmd_valid = active && (cnt == CNT_CMD_LAST);
    assign done      = active && (cnt == CNT_LAST);
    assign abort     = first_bit && in_frame;
    assign frame     = {sreg[FRAME_LEN-2:0], SDI};

    // Counter and shifter; CS high clears them without a clock.
    always_ff @(posedge SCLK or negedge reset or posedge CS) begin
        if (!reset) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (CS) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (cnt != CNT_FULL) begin
            cnt  <= cnt + CNT_W'(1);
            sreg <= frame;
        end
    end

    // in_frame survives CS so a cut-short frame is seen on the next one.
    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            in_frame <= 1'b0;
        end else if (done) begin
            in_frame <= 1'b0;
        end else if (first_bit) begin
            in_frame <= 1'b1;
        end
    end

    // Phase follows the bit counter.
    always_comb begin
        phase = PH_CMD;
        if (cnt == CNT_FULL) begin
            phase = PH_DONE;
        end else if (cnt >= CNT_CMD) begin
            phase = PH_DATA;
        end
    end

endmodule

// File: rtl/spi_regfile_programmer.sv
// Addressed SPI configuration register file with shadow/live
// double buffering, atomic apply, read-back and error count.
module spi_regfile_programmer
    import spi_prog_pkg::*;
#(
    parameter int                           NUM_REGS     = 8,
    parameter int                           DATA_W       = 8,
    parameter int                           ADDR_W       = 7,
    parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VALUES = '0,
    parameter int                           AUTO_APPLY   = 0
) (
    input  logic                         reset,
    input  logic                         SCLK,
    input  logic                         CS,
    input  logic                         SDI,
    output logic                         SDO,
    output logic                         SDO_OE,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         apply_toggle,
    output logic [7:0]                   err_cnt
);

    localparam int CMD_W     = 1 + ADDR_W;
    localparam int FRAME_LEN = CMD_W + DATA_W;
    localparam int RW_IDX    = rw_bit(ADDR_W);

    localparam logic [ADDR_W-1:0] APPLY_ADDR  = ADDR_W'(apply_addr(ADDR_W));
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_addr(ADDR_W));
    localparam logic [ADDR_W-1:0] REG_LIMIT   = ADDR_W'(NUM_REGS);

    phase_e                 phase;
    logic                   cmd_valid;
    logic                   done;
    logic                   abort;
    logic [FRAME_LEN-1:0]   frame;

    logic [DATA_W-1:0] shadow   [NUM_REGS];
    logic [DATA_W-1:0] live     [NUM_REGS];
    logic [DATA_W-1:0] shadow_n [NUM_REGS];
    logic [DATA_W-1:0] live_n   [NUM_REGS];
    logic              toggle_n;
    logic              err_inc;
    logic              err_clr;

    logic              cmd_rw;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_rw;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_target;
    logic              rd_known;
    logic [DATA_W-1:0] rd_shift;
    logic              rd_active;

    spi_frame_rx #(
        .CMD_W  (CMD_W),
        .DATA_W (DATA_W)
    ) u_rx (
        .SCLK      (SCLK),
        .reset     (reset),
        .CS        (CS),
        .SDI       (SDI),
        .phase     (phase),
        .cmd_valid (cmd_valid),
        .done      (done),
        .abort     (abort),
        .frame     (frame)
    );

    // Command view on the last command bit; full view on the last data bit.
    assign cmd_rw  = frame[RW_IDX];
    assign rd_addr = frame[ADDR_W-1:0];
    assign wr_rw   = frame[FRAME_LEN-1];
    assign wr_addr = frame[FRAME_LEN-2 -: ADDR_W];
    assign wr_data = frame[DATA_W-1:0];

    // Read target selection for the address just received.
    always_comb begin
        rd_target = '0;
        rd_known  = 1'b0;
        unique case (1'b1)
            rd_addr < REG_LIMIT: begin
                rd_known = 1'b1;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (rd_addr == ADDR_W'(i)) begin
                        rd_target = shadow[i];
                    end
                end
            end
            rd_addr == STATUS_ADDR: begin
                rd_known       = 1'b1;
                rd_target[7:0] = err_cnt;
            end
            default: begin
                rd_known = 1'b0;
            end
        endcase
    end

    // Next-state of the register file, apply toggle and error events.
    always_comb begin
        shadow_n = shadow;
        live_n   = live;
        toggle_n = apply_toggle;
        err_inc  = 1'b0;
        err_clr  = 1'b0;
        if (abort) begin
            err_inc = 1'b1;
        end
        if (cmd_valid && cmd_rw && !rd_known) begin
            err_inc = 1'b1;
        end
        if (done && !wr_rw) begin
            unique case (1'b1)
                wr_addr < REG_LIMIT: begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (wr_addr == ADDR_W'(i)) begin
                            shadow_n[i] = wr_data;
                            if (AUTO_APPLY != 0) begin
                                live_n[i] = wr_data;
                            end
                        end
                    end
                    if (AUTO_APPLY != 0) begin
                        toggle_n = ~apply_toggle;
                    end
                end
                wr_addr == APPLY_ADDR: begin
                    if (wr_data[7:0] == APPLY_MAGIC) begin
                        live_n   = shadow;
                        toggle_n = ~apply_toggle;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                wr_addr == STATUS_ADDR: begin
                    err_clr = 1'b1;
                end
                default: begin
                    err_inc = 1'b1;
                end
            endcase
        end
    end

    // Register file, apply toggle and saturating error counter.
    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow[i] <= RESET_VALUES[i*DATA_W +: DATA_W];
                live[i]   <= RESET_VALUES[i*DATA_W +: DATA_W];
            end
            apply_toggle <= 1'b0;
            err_cnt      <= '0;
        end else begin
            shadow       <= shadow_n;
            live         <= live_n;
            apply_toggle <= toggle_n;
            if (err_clr) begin
                err_cnt <= '0;
            end else if (err_inc && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // Read shifter: loaded on the last command bit, advanced each data bit.
    always_ff @(posedge SCLK or negedge reset or posedge CS) begin
        if (!reset) begin
            rd_active <= 1'b0;
            rd_shift  <= '0;
        end else if (CS) begin
            rd_active <= 1'b0;
        end else if (cmd_valid) begin
            rd_active <= cmd_rw;
            rd_shift  <= rd_target;
        end else begin
            if (rd_active) begin
                rd_shift <= rd_shift << 1;
            end
            if (done) begin
                rd_active <= 1'b0;
            end
        end
    end

    // SDO launches on the falling edge so the master samples it on the rising.
    always_ff @(negedge SCLK or negedge reset or posedge CS) begin
        if (!reset) begin
            SDO    <= 1'b0;
            SDO_OE <= 1'b0;
        end else if (CS) begin
            SDO    <= 1'b0;
            SDO_OE <= 1'b0;
        end else begin
            SDO_OE <= rd_active && (phase == PH_DATA);
            SDO    <= (rd_active && (phase == PH_DATA)) ?
                      rd_shift[DATA_W-1] : 1'b0;
        end
    end

    // Flatten the live image for the trim fields.
    always_comb begin
        regs_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_out[i*DATA_W +: DATA_W] = live[i];
        end
    end

endmodule

// File: tb/tb_spi_regfile_programmer.sv
// Bench for spi_regfile_programmer: SPI frames driven by tasks,
// read-back bits checked against a queue of expected SDO bits.
module tb_spi_regfile_programmer;

    localparam logic [63:0] RV = 64'h8877_6655_4433_2211;

    logic        SCLK;
    logic        CS;
    logic        SDI;
    logic        rst0;
    logic        rst1;
    logic        SDO0, SDO_OE0, tog0;
    logic        SDO1, SDO_OE1, tog1;
    logic [63:0] regs0, regs1;
    logic [7:0]  err0, err1;

    int   checks;
    int   errors;
    int   oe_cycles;
    logic exp_q[$];
    logic exp_bit;

    spi_regfile_programmer #(
        .NUM_REGS(8), .DATA_W(8), .ADDR_W(7),
        .RESET_VALUES(RV), .AUTO_APPLY(0)
    ) dut0 (
        .reset(rst0), .SCLK(SCLK), .CS(CS), .SDI(SDI),
        .SDO(SDO0), .SDO_OE(SDO_OE0), .regs_out(regs0),
        .apply_toggle(tog0), .err_cnt(err0)
    );

    spi_regfile_programmer #(
        .NUM_REGS(8), .DATA_W(8), .ADDR_W(7),
        .RESET_VALUES(RV), .AUTO_APPLY(1)
    ) dut1 (
        .reset(rst1), .SCLK(SCLK), .CS(CS), .SDI(SDI),
        .SDO(SDO1), .SDO_OE(SDO_OE1), .regs_out(regs1),
        .apply_toggle(tog1), .err_cnt(err1)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    // SDO monitor: pops one expected bit per driven bit period.
    always @(negedge SCLK) begin
        #1;
        if (SDO_OE0 === 1'b1) begin
            oe_cycles++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sdo_extra: SDO_OE high, SDO=%b, nothing expected", SDO0);
            end else begin
                exp_bit = exp_q.pop_front();
                if (SDO0 !== exp_bit) begin
                    errors++;
                    $display("FAIL sdo_bit: got %b expected %b", SDO0, exp_bit);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] wr(input logic [6:0] a, input logic [7:0] d);
        return {16'h0, 1'b0, a, d};
    endfunction

    function automatic logic [31:0] rd(input logic [6:0] a);
        return {16'h0, 1'b1, a, 8'h00};
    endfunction

    task automatic push_read(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) exp_q.push_back(v[i]);
    endtask

    // Caller stands 2 time units after a negedge; sends w[nbits-1:0] MSB first.
    task automatic send(input logic [31:0] w, input int nbits, input bit raise);
        CS = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            SDI = w[i];
            @(posedge SCLK);
            @(negedge SCLK);
            #2;
        end
        if (raise) begin
            CS  = 1'b1;
            SDI = 1'b0;
            @(negedge SCLK);
            #2;
        end
    endtask

    task automatic test_reset;
        rst0 = 1'b0; rst1 = 1'b0; CS = 1'b1; SDI = 1'b0;
        repeat (3) @(negedge SCLK);
        #2;
        checks++; if (regs0 !== RV) begin errors++; $display("FAIL reset_regs: got %h expected %h", regs0, RV); end
        checks++; if (err0 !== 8'h00) begin errors++; $display("FAIL reset_err: got %h expected 00", err0); end
        checks++; if (tog0 !== 1'b0) begin errors++; $display("FAIL reset_toggle: got %b expected 0", tog0); end
        checks++; if (SDO0 !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b expected 0", SDO0); end
        checks++; if (SDO_OE0 !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", SDO_OE0); end
        rst0 = 1'b1;
        @(negedge SCLK);
        #2;
    endtask

    task automatic test_write_apply;
        send(wr(7'd2, 8'h3C), 16, 1);
        checks++; if (regs0[23:16] !== 8'h33) begin errors++; $display("FAIL shadow_only: got %h expected 33", regs0[23:16]); end
        checks++; if (tog0 !== 1'b0) begin errors++; $display("FAIL shadow_toggle: got %b expected 0", tog0); end
        send(wr(7'h7F, 8'hA5), 16, 1);
        checks++; if (regs0 !== 64'h8877_6655_443C_2211) begin errors++; $display("FAIL apply_regs: got %h expected 88776655443c2211", regs0); end
        checks++; if (tog0 !== 1'b1) begin errors++; $display("FAIL apply_toggle: got %b expected 1", tog0); end
        checks++; if (err0 !== 8'h00) begin errors++; $display("FAIL apply_err: got %h expected 00", err0); end
    endtask

    task automatic test_read;
        oe_cycles = 0;
        push_read(8'h3C);
        send(rd(7'd2), 16, 1);
        checks++; if (oe_cycles !== 8) begin errors++; $display("FAIL read_oe_len: got %0d expected 8", oe_cycles); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL read_left: got %0d bits unread expected 0", exp_q.size()); end
        checks++; if (regs0 !== 64'h8877_6655_443C_2211) begin errors++; $display("FAIL read_live: got %h expected 88776655443c2211", regs0); end
        exp_q.delete();
    endtask

    task automatic test_abort;
        send(wr(7'd1, 8'h99) >> 6, 10, 1);
        send(wr(7'd5, 8'h55), 16, 1);
        checks++; if (err0 !== 8'h01) begin errors++; $display("FAIL abort_err: got %h expected 01", err0); end
        push_read(8'h22);
        send(rd(7'd1), 16, 1);
        push_read(8'h01);
        send(rd(7'h7E), 16, 1);
        send(wr(7'h7E, 8'h00), 16, 1);
        checks++; if (err0 !== 8'h00) begin errors++; $display("FAIL status_clear: got %h expected 00", err0); end
        oe_cycles = 0;
        push_read(8'h20);
        exp_q.delete();
        exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        send(rd(7'd2) >> 6, 10, 0);
        CS = 1'b1;
        #1;
        checks++; if (SDO_OE0 !== 1'b0 || SDO0 !== 1'b0) begin errors++; $display("FAIL cs_release: got oe=%b sdo=%b expected 0 0", SDO_OE0, SDO0); end
        @(negedge SCLK);
        #2;
        checks++; if (oe_cycles !== 3) begin errors++; $display("FAIL cut_read_len: got %0d expected 3", oe_cycles); end
        push_read(8'h01);
        send(rd(7'h7E), 16, 1);
        send(wr(7'h7E, 8'h00), 16, 1);
        checks++; if (err0 !== 8'h00) begin errors++; $display("FAIL status_clear2: got %h expected 00", err0); end
    endtask

    task automatic test_bad_addr;
        send(wr(7'h10, 8'h77), 16, 1);
        checks++; if (err0 !== 8'h01) begin errors++; $display("FAIL bad_wr_err: got %h expected 01", err0); end
        send(wr(7'h7F, 8'h5A), 16, 1);
        checks++; if (err0 !== 8'h02) begin errors++; $display("FAIL bad_key_err: got %h expected 02", err0); end
        checks++; if (tog0 !== 1'b1) begin errors++; $display("FAIL bad_key_toggle: got %b expected 1", tog0); end
        checks++; if (regs0 !== 64'h8877_6655_443C_2211) begin errors++; $display("FAIL bad_key_regs: got %h expected 88776655443c2211", regs0); end
        push_read(8'h00);
        send(rd(7'h20), 16, 1);
        checks++; if (err0 !== 8'h03) begin errors++; $display("FAIL bad_rd_err: got %h expected 03", err0); end
    endtask

    task automatic test_mid_reset;
        send(wr(7'd1, 8'h99) >> 4, 12, 0);
        rst0 = 1'b0;
        #1;
        checks++; if (regs0 !== RV) begin errors++; $display("FAIL midrst_regs: got %h expected %h", regs0, RV); end
        checks++; if (err0 !== 8'h00) begin errors++; $display("FAIL midrst_err: got %h expected 00", err0); end
        checks++; if (tog0 !== 1'b0) begin errors++; $display("FAIL midrst_toggle: got %b expected 0", tog0); end
        CS = 1'b1;
        @(negedge SCLK);
        rst0 = 1'b1;
        @(negedge SCLK);
        #2;
        send(wr(7'd1, 8'h99), 16, 1);
        send(wr(7'h7F, 8'hA5), 16, 1);
        checks++; if (regs0 !== 64'h8877_6655_4433_9911) begin errors++; $display("FAIL midrst_next: got %h expected 8877665544339911", regs0); end
        checks++; if (err0 !== 8'h00) begin errors++; $display("FAIL midrst_noabort: got %h expected 00", err0); end
    endtask

    task automatic test_overlong;
        send({wr(7'd4, 8'h5E), 4'hF}, 20, 1);
        send(wr(7'h7F, 8'hA5), 16, 1);
        checks++; if (regs0 !== 64'h8877_665E_4433_9911) begin errors++; $display("FAIL overlong_regs: got %h expected 8877665e44339911", regs0); end
        checks++; if (err0 !== 8'h00) begin errors++; $display("FAIL overlong_err: got %h expected 00", err0); end
    endtask

    task automatic test_saturate;
        for (int n = 0; n < 256; n++) send(wr(7'h10, 8'h00), 16, 1);
        checks++; if (err0 !== 8'hFF) begin errors++; $display("FAIL sat_err: got %h expected ff", err0); end
        push_read(8'hFF);
        send(rd(7'h7E), 16, 1);
        send(wr(7'h7E, 8'h00), 16, 1);
        checks++; if (err0 !== 8'h00) begin errors++; $display("FAIL sat_clear: got %h expected 00", err0); end
    endtask

    task automatic test_auto_apply;
        rst1 = 1'b1;
        @(negedge SCLK);
        #2;
        send(wr(7'd0, 8'hFF) >> 1, 15, 0);
        checks++; if (regs1[7:0] !== 8'h11) begin errors++; $display("FAIL auto_early: got %h expected 11", regs1[7:0]); end
        send(32'(wr(7'd0, 8'hFF) & 32'h1), 1, 1);
        checks++; if (regs1[7:0] !== 8'hFF) begin errors++; $display("FAIL auto_live: got %h expected ff", regs1[7:0]); end
        checks++; if (tog1 !== 1'b1) begin errors++; $display("FAIL auto_toggle: got %b expected 1", tog1); end
        checks++; if (regs0[7:0] !== 8'h11) begin errors++; $display("FAIL manual_live: got %h expected 11", regs0[7:0]); end
        send(wr(7'h7F, 8'hA5), 16, 1);
        checks++; if (tog1 !== 1'b0) begin errors++; $display("FAIL auto_apply_cmd: got %b expected 0", tog1); end
        checks++; if (regs0[7:0] !== 8'hFF) begin errors++; $display("FAIL manual_apply: got %h expected ff", regs0[7:0]); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        oe_cycles = 0;
        test_reset();
        test_write_apply();
        test_read();
        test_abort();
        test_bad_addr();
        test_mid_reset();
        test_overlong();
        test_saturate();
        test_auto_apply();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
